// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_unit
// Brief    : Two-stage RV32M MUL/MULH/MULHSU/MULHU front end around Multiplier32.
// Revision : 1.0
// ============================================================================
module mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);
  localparam logic [1:0] c_op_mul    = 2'b00;
  localparam logic [1:0] c_op_mulh   = 2'b01;
  localparam logic [1:0] c_op_mulhsu = 2'b10;

  logic        r_s1_valid;
  logic        r_s2_valid;
  logic        r_neg;
  logic [1:0]  r_op;
  logic [31:0] r_a1;
  logic [31:0] r_a2;
  logic [31:0] r_result;

  logic        w_adv2;
  logic        w_accept;
  logic        w_move;
  logic        w_sign1;
  logic        w_sign2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [63:0] w_prod;
  logic [63:0] w_q;

  assign w_adv2   = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_adv2;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_move   = r_s1_valid && w_adv2 && !flush;

  // Magnitudes are formed here so the negate cost stays off the multiply path.
  assign w_sign1 = ((in_op == c_op_mulh) || (in_op == c_op_mulhsu)) && in_rs1[31];
  assign w_sign2 = (in_op == c_op_mulh) && in_rs2[31];
  assign w_mag1  = w_sign1 ? (~in_rs1 + 32'd1) : in_rs1;
  assign w_mag2  = w_sign2 ? (~in_rs2 + 32'd1) : in_rs2;

  Multiplier32 u_mult (
    .a (r_a1),
    .b (r_a2),
    .p (w_prod)
  );

  assign w_q = r_neg ? (~w_prod + 64'd1) : w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      // With in_ready high, S1 is either empty or draining into S2 this edge.
      if (in_ready) r_s1_valid <= w_accept;
      if (w_adv2)   r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1     <= 32'd0;
      r_a2     <= 32'd0;
      r_neg    <= 1'b0;
      r_op     <= c_op_mul;
      r_result <= 32'd0;
    end else begin
      if (w_accept) begin
        r_a1  <= w_mag1;
        r_a2  <= w_mag2;
        r_neg <= w_sign1 ^ w_sign2;
        r_op  <= in_op;
      end
      if (w_move) begin
        r_result <= (r_op == c_op_mul) ? w_q[31:0] : w_q[63:32];
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;

endmodule

// Unsigned 32x32 -> 64 combinational product core.
module Multiplier32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  assign p = {32'd0, a} * {32'd0, b};
endmodule
`default_nettype wire
